seq_mult_unit: RTL and testbench

//   Parametrised multi-cycle shift-add multiplier with a start/done handshake and a
//   per-operation signed/unsigned mode. It owns the control FSM and the

---
 rtl/seq_mult_unit.sv | 120 ++++++++++++
 tb/tb_seq_mult_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-add multiplier with a start/done handshake.
// Signed operations multiply magnitudes and negate the product at the end.
// The product registers change only when an operation completes.
module seq_mult_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             overflow
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           count;
  logic [WIDTH-1:0]           mcand_abs;
  logic [2*WIDTH-1:0]         prod;
  logic                       neg;
  logic                       mode;
  logic                       op_signed;
  logic [WIDTH:0]             sum;
  logic signed [2*WIDTH-1:0]  result;

  // Magnitude of an operand; the most negative value maps onto its exact
  // unsigned magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Product does not fit in WIDTH bits for the given mode.
  function automatic logic out_of_range(input logic [2*WIDTH-1:0] p,
                                        input logic               sgn);
    if (sgn)
      return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
    return p[2*WIDTH-1:WIDTH] != '0;
  endfunction

  // Adder keeps the carry so the shift below never loses the top bit.
  always_comb begin
    op_signed = is_signed & SIGNED_EN;
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand_abs};
    result    = neg ? -$signed(prod) : $signed(prod);
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == LAST) state_nxt = SIGN;
      end
      SIGN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        count <= '0;
      else if (state == CALC)
        count <= count + CNT_W'(1);
    end
  end

  // Operand capture and the shift-add iteration; no reset needed on data.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mode      <= op_signed;
      neg       <= op_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      mcand_abs <= magnitude(multiplicand, op_signed);
      prod      <= {{WIDTH{1'b0}}, magnitude(multiplier, op_signed)};
    end else if (state == CALC) begin
      prod <= prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
    end
  end

  // Visible result registers, loaded once as DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_hi <= '0;
      product_lo <= '0;
      overflow   <= 1'b0;
    end else if (state == SIGN) begin
      {product_hi, product_lo} <= $unsigned(result);
      overflow                 <= out_of_range($unsigned(result), mode);
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: a scoreboard of expected products is
// filled as operations are issued and drained when done pulses.
module tb_seq_mult_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy, done, overflow;
  logic [W-1:0] product_hi, product_lo;

  logic         start2 = 1'b0;
  logic         is_signed2 = 1'b0;
  logic [W-1:0] multiplicand2 = '0;
  logic [W-1:0] multiplier2 = '0;
  logic         busy2, done2, overflow2;
  logic [W-1:0] product_hi2, product_lo2;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  seq_mult_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product_hi(product_hi),
    .product_lo(product_lo), .overflow(overflow)
  );

  seq_mult_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start2), .is_signed(is_signed2),
    .multiplicand(multiplicand2), .multiplier(multiplier2),
    .busy(busy2), .done(done2), .product_hi(product_hi2),
    .product_lo(product_lo2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product using the simulator's own multiply.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t              e;
    logic [2*W-1:0]    p;
    logic signed [2*W-1:0] sa, sb_;
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sb_ = {{W{b[W-1]}}, b};
      p   = sa * sb_;
      e.ovf = p[2*W-1:W] != {W{p[W-1]}};
    end else begin
      p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.ovf = p[2*W-1:W] != '0;
    end
    e.hi = p[2*W-1:W];
    e.lo = p[W-1:0];
    return e;
  endfunction

  // Scoreboard drain on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product_hi", 64'(product_hi), 64'(e.hi));
        check("product_lo", 64'(product_lo), 64'(e.lo));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b; is_signed = s;
    @(negedge clk);
    start = 1'b0;
    multiplicand = $urandom; multiplier = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 1;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [W-1:0] hi, input logic [W-1:0] lo,
                     input logic ovf);
    exp_t e;
    int   n;
    e.hi = hi; e.lo = lo; e.ovf = ovf;
    sb.push_back(e);
    drive(a, b, s);
    wait_done(80, n);
    check({tag, "_latency"}, 64'(n), 64'(W + 2));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_hold_lo"}, 64'(product_lo), 64'(lo));
  endtask

  initial begin
    int   n, k, d0;
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rs;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(product_hi), 64'(0));
    check("rst_lo", 64'(product_lo), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run("unsigned_basic", 32'h0000_0002, 32'hC000_0006, 1'b0, 32'h0000_0001, 32'h8000_000C, 1'b1);
    run("signed_neg3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run("unsigned_neg3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1, 1'b1);
    run("signed_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b1);
    run("unsigned_maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    run("zero_b", 32'h4000_000E, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    run("signed_min_x1", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i);
      e = model(ra, rb, rs);
      run("random", ra, rb, rs, e.hi, e.lo, e.ovf);
    end

    // Second start in the middle of an operation must be dropped.
    e.hi = 32'h0; e.lo = 32'd63; e.ovf = 1'b0;
    sb.push_back(e);
    d0 = done_cnt;
    drive(32'd7, 32'd9, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; multiplicand = 32'd1; multiplier = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(80, n);
    repeat (45) @(negedge clk);
    check("ignored_start_done_count", 64'(done_cnt - d0), 64'(1));

    // Continuous start: one operation per WIDTH+3 cycles.
    e.hi = 32'h0; e.lo = 32'h0001_2340; e.ovf = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; multiplicand = 32'h0000_1234; multiplier = 32'h0000_0010; is_signed = 1'b0;
    @(negedge clk);
    wait_done(80, n);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 80);
    start = 1'b0;
    check("b2b_period", 64'(k), 64'(W + 3));
    repeat (3) @(negedge clk);

    // Asynchronous abort in the middle of CALC.
    drive(32'h0001_2345, 32'h0000_0777, 1'b0);
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'(1));
    check("pre_abort_lo_held", 64'(product_lo), 64'(32'h0001_2340));
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(product_hi), 64'(0));
    check("abort_lo", 64'(product_lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run("after_reset", 32'd3, 32'd7, 1'b0, 32'h0, 32'd21, 1'b0);

    // Build without signed support treats is_signed as unsigned.
    @(negedge clk);
    start2 = 1'b1; is_signed2 = 1'b1; multiplicand2 = 32'hFFFF_FFFF; multiplier2 = 32'd2;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("unsigned_build_latency", 64'(n), 64'(W + 2));
    check("unsigned_build_hi", 64'(product_hi2), 64'(32'h1));
    check("unsigned_build_lo", 64'(product_lo2), 64'(32'hFFFF_FFFE));
    check("unsigned_build_ovf", 64'(overflow2), 64'(1));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
